gates_bist_ctrl: RTL
====================

# gates_bist_ctrl

Built-in self-test sequencer for the two-input basic-gates block, which has gate-level outputs `cgate[3:0]` and dataflow outputs `cout[3:0]`. On `start`, the controller drives the block's `a`/`b` inputs through all four combinations in order 00, 01, 10, 11. After a programmable settle time it checks both output vectors against the expected truth table, then reports pass/fail with a per-combination failure mask. It replaces hand-written stimulus with an on-chip, self-checking sequencer that sits directly in front of the gates block.

## Interface
Parameters:
- `SETTLE`, default 2: cycles `a_o`/`b_o` are held stable before outputs are sampled. Legal range 1–15.

Ports:
- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a test run. Sampled only in IDLE.
- `a_o`, output, 1: drives gates block input `a`.
- `b_o`, output, 1: drives gates block input `b`.
- `cgate_i`, input, 4: gate-level outputs of the gates block.
- `cout_i`, input, 4: dataflow outputs of the gates block.
- `busy`, output, 1: run in progress.
- `done`, output, 1: one-cycle pulse at end of run.
- `pass`, output, 1: last run had no mismatches. Held until the next accepted `start`.
- `fail_mask`, output, 4: bit k set means combination k mismatched. Held until the next accepted `start`.

## Operation
- Combination index `c[1:0]` maps to `a_o = c[1]`, `b_o = c[0]`.
- Expected vector `exp[3:0]`: bit 0 = a AND b, bit 1 = a OR b, bit 2 = a XOR b, bit 3 = a NAND b.
- A combination fails if `cgate_i != exp` or `cout_i != exp`. Both vectors are always checked.
- States:
  - IDLE:
    - `start=1` → SETTLE.
    - On that transition: `c=0`, settle counter=0, `fail_mask=0`, `pass=0`, `busy=1`.
    - `start=0` → stay in IDLE.
  - SETTLE:
    - Counter increments each cycle.
    - When counter reaches `SETTLE-1` → CHECK.
    - `a_o`/`b_o` are held constant for the whole state.
  - CHECK (one cycle):
    - Compare `cgate_i`/`cout_i` with `exp(c)` and OR the result into `fail_mask[c]`.
    - If `c==3` → DONE. Otherwise `c` increments, counter clears, and the state returns to SETTLE with the new combination.
  - DONE (one cycle):
    - `done=1`, `busy=0`, `pass = (fail_mask==0)` including the final combination's result.
    - → IDLE.
- `start` outside IDLE, including the DONE cycle, is ignored and never queued.
- After the run, `a_o`/`b_o` remain at combination 11 until the next run or reset.
- `pass`/`fail_mask` are cleared only by an accepted `start` or by `rst`.

## Timing
- Reset values: `a_o=0`, `b_o=0`, `busy=0`, `done=0`, `pass=0`, `fail_mask=0`, state IDLE, `c=0`, counter=0.
- `rst` has priority over everything. Asserting it mid-run aborts to IDLE with all outputs at reset values, and no `done` pulse is generated.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Let edge E0 be the edge that samples `start=1` in IDLE.
  - From E0: `busy=1`, `a_o=b_o=0`.
  - Combination k is applied from edge E0+k·(SETTLE+1).
  - Combination k is sampled at edge E0+(k+1)·(SETTLE+1) − 0, i.e. the CHECK-state edge.
  - `done` is high for the cycle after edge E0+4·(SETTLE+1). With SETTLE=2 that is edge E0+12.
  - `busy` falls at the same edge `done` rises.
- Earliest re-start: `start` sampled at the edge after `done` (IDLE again). Minimum period between runs is 4·(SETTLE+1)+2 cycles.
- `cgate_i`/`cout_i` must be valid at least SETTLE cycles after `a_o`/`b_o` change. They are ignored outside CHECK.

## Test plan
- Reset, then wait 5 cycles with `start=0` → all outputs 0, and `a_o`/`b_o` do not toggle.
- Correct gates model, SETTLE=2, pulse `start` → `a_o`/`b_o` sequence 00, 01, 10, 11, each held 3 cycles; `done` pulse at E0+12; `pass=1`; `fail_mask=0000`.
- Fault injection: `cout_i[2]` stuck-at-0 → mismatch for combinations 01 and 10 (XOR=1) → `pass=0`, `fail_mask=0110`. Then rerun with the fault removed → `pass=1`, `fail_mask=0000`.
- Fault injection: `cgate_i[3]` (NAND) inverted → `fail_mask=1111`, `pass=0`. The flags hold unchanged for 20 idle cycles.
- Assert `start` repeatedly during the run and in the DONE cycle → a single `done` at E0+12 and no second run. A `start` one cycle after `done` is accepted.
- Assert `rst` at E0+5 → at the next edge `busy=0`, `a_o=b_o=0`, state IDLE, and no `done` pulse. A new `start` then completes normally.

Source files
------------

// File: rtl/gates_bist_ctrl.sv
// gates_bist_ctrl: self-test sequencer for the two-input basic-gates block.
// Walks a/b through 00,01,10,11, checks both output vectors, reports a mask.
module gates_bist_ctrl #(
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a_o,
   output logic       b_o,
   input  logic [3:0] cgate_i,
   input  logic [3:0] cout_i,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

   state_t     state_q, state_d;
   logic [1:0] c_q, c_d;
   logic [3:0] cnt_q, cnt_d;
   logic       a_q, a_d;
   logic       b_q, b_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [3:0] mask_q, mask_d;

   logic [3:0] exp_v;
   logic       mismatch;
   logic [3:0] mask_upd;
   logic [1:0] c_nxt;

   // Truth table of the gates block for the combination under test
   always_comb begin
      exp_v    = {~(c_q[1] & c_q[0]), c_q[1] ^ c_q[0],
                  c_q[1] | c_q[0], c_q[1] & c_q[0]};
      mismatch = (cgate_i != exp_v) || (cout_i != exp_v);
      mask_upd = mask_q | (4'(mismatch) << c_q);
      c_nxt    = c_q + 2'd1;
   end

   // Next-state and registered-output logic of the sequencer
   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      mask_d  = mask_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SETTLE;
               c_d     = 2'd0;
               cnt_d   = 4'd0;
               a_d     = 1'b0;
               b_d     = 1'b0;
               busy_d  = 1'b1;
               pass_d  = 1'b0;
               mask_d  = 4'd0;
            end
         end
         S_SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_CHECK: begin
            mask_d = mask_upd;
            if (c_q == 2'd3) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               pass_d  = (mask_upd == 4'd0);
            end else begin
               state_d = S_SETTLE;
               c_d     = c_nxt;
               cnt_d   = 4'd0;
               a_d     = c_nxt[1];
               b_d     = c_nxt[0];
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers, synchronous reset has priority
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         c_q     <= 2'd0;
         cnt_q   <= 4'd0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         mask_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         mask_q  <= mask_d;
      end
   end

   assign a_o       = a_q;
   assign b_o       = b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_mask = mask_q;

endmodule
